// File: rtl/fxdiv_pkg.sv
// ---------------------------------------------------------------------------
// fxdiv_pkg
// Shared types and helpers for the sequential fixed-point divider.
//   state_t      : controller states (IDLE, RUN, FIN)
//   sat_t        : saturation limits expressed as quotient magnitudes
//   calc_iters() : number of quotient bits produced, N = WIDTH + FRAC
//   sat_limits() : largest positive magnitude and most-negative magnitude
//                  for a given width and signedness
// ---------------------------------------------------------------------------
package fxdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    typedef struct packed {
        logic [63:0] pos_max;   // largest representable positive value
        logic [63:0] neg_mag;   // magnitude of the most-negative value
    } sat_t;

    function automatic int unsigned calc_iters(input int unsigned width,
                                               input int unsigned frac);
        return width + frac;
    endfunction

    function automatic sat_t sat_limits(input int unsigned width,
                                        input logic        is_signed);
        sat_t s;
        s.neg_mag = 64'd1 << (width - 1);
        s.pos_max = is_signed ? (s.neg_mag - 64'd1) : ((s.neg_mag << 1) - 64'd1);
        return s;
    endfunction

endpackage

// File: rtl/fxdiv_iter_counter.sv
// ---------------------------------------------------------------------------
// fxdiv_iter_counter
// Mod-N iteration counter with synchronous clear and enable.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (count -> 0)
//   i_clr  : synchronous clear (count -> 0)
//   i_en   : advance the count; wraps from N-1 to 0
//   o_tc   : terminal count, high while count == N-1
// ---------------------------------------------------------------------------
module fxdiv_iter_counter #(
    parameter int unsigned N = 14
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned    CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
        end
    end

    assign o_tc = (r_count == LAST);

endmodule

// File: rtl/fixed_point_divider_param.sv
// ---------------------------------------------------------------------------
// fixed_point_divider_param
// Sequential restoring divider computing Q = (A << FRAC) / B, one quotient
// bit per cycle, with signed/unsigned mode, saturation and divide-by-zero.
//   clk         : clock
//   rst         : synchronous active-high reset
//   start       : request, sampled only while ready
//   signed_mode : 0 unsigned, 1 two's complement (captured with start)
//   a_in, b_in  : dividend / divisor (captured with start)
//   ready       : high in IDLE
//   done        : one-cycle pulse, results valid from this cycle
//   q_out       : quotient, same fixed-point format as the operands
//   ov          : quotient saturated
//   dvz         : divisor was zero
// ---------------------------------------------------------------------------
module fixed_point_divider_param
    import fxdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned FRAC  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] q_out,
    output logic             ov,
    output logic             dvz
);

    localparam int unsigned  N      = calc_iters(WIDTH, FRAC);
    localparam sat_t         SAT_U  = sat_limits(WIDTH, 1'b0);
    localparam sat_t         SAT_S  = sat_limits(WIDTH, 1'b1);
    localparam logic [N-1:0] LIM_U  = SAT_U.pos_max[N-1:0];
    localparam logic [N-1:0] LIM_SP = SAT_S.pos_max[N-1:0];
    localparam logic [N-1:0] LIM_SN = SAT_S.neg_mag[N-1:0];

    state_t           r_state, w_state_nx;
    logic             r_signed, r_neg, r_dvz_pend;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_rem;
    logic [N-1:0]     r_dvd, r_quo;
    logic             r_done, r_ov, r_dvz;
    logic [WIDTH-1:0] r_q;

    logic             w_accept, w_run, w_tc, w_b_zero;
    logic             w_a_neg, w_b_neg, w_ge, w_ov;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_mag_lo, w_q;
    logic [WIDTH:0]   w_rem_sh;
    logic [N-1:0]     w_lim, w_mag;

    assign w_accept = (r_state == IDLE) && start;
    assign w_run    = (r_state == RUN);
    assign w_b_zero = (b_in == '0);
    assign w_a_neg  = signed_mode & a_in[WIDTH-1];
    assign w_b_neg  = signed_mode & b_in[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a_in : a_in;
    assign w_b_mag  = w_b_neg ? -b_in : b_in;

    fxdiv_iter_counter #(
        .N (N)
    ) u_iter_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (w_accept),
        .i_en  (w_run),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nx = w_b_zero ? FIN : RUN;
            RUN:     if (w_tc)  w_state_nx = FIN;
            FIN:     w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    assign w_rem_sh = (r_rem << 1) | (WIDTH+1)'(r_dvd[N-1]);
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});

    // Final formatting. A zero divisor is forced to the saturation limit of
    // the dividend's sign; r_neg holds that sign in the divide-by-zero case.
    always_comb begin
        w_lim    = !r_signed ? LIM_U : (r_neg ? LIM_SN : LIM_SP);
        w_ov     = !r_dvz_pend && (r_quo > w_lim);
        w_mag    = (r_dvz_pend || w_ov) ? w_lim : r_quo;
        w_mag_lo = w_mag[WIDTH-1:0];
        w_q      = r_neg ? -w_mag_lo : w_mag_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_signed   <= 1'b0;
            r_neg      <= 1'b0;
            r_dvz_pend <= 1'b0;
            r_b        <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_quo      <= '0;
            r_done     <= 1'b0;
            r_q        <= '0;
            r_ov       <= 1'b0;
            r_dvz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_signed   <= signed_mode;
                    r_neg      <= w_b_zero ? w_a_neg : (w_a_neg ^ w_b_neg);
                    r_dvz_pend <= w_b_zero;
                    r_b        <= w_b_mag;
                    r_rem      <= '0;
                    r_quo      <= '0;
                    r_dvd      <= N'(w_a_mag) << FRAC;
                end
                RUN: begin
                    r_rem <= w_ge ? (w_rem_sh - {1'b0, r_b}) : w_rem_sh;
                    r_dvd <= r_dvd << 1;
                    r_quo <= (r_quo << 1) | N'(w_ge);
                end
                FIN: begin
                    r_done <= 1'b1;
                    r_q    <= w_q;
                    r_ov   <= w_ov;
                    r_dvz  <= r_dvz_pend;
                end
                default: ;
            endcase
        end
    end

    assign ready = (r_state == IDLE);
    assign done  = r_done;
    assign q_out = r_q;
    assign ov    = r_ov;
    assign dvz   = r_dvz;

endmodule

// File: tb/tb_fixed_point_divider_param.sv
module tb_fixed_point_divider_param;

    localparam int unsigned W   = 10;
    localparam int unsigned F   = 4;
    localparam int          LAT = 15;

    typedef struct packed {
        logic [9:0] q;
        logic       ov;
        logic       dvz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       signed_mode = 1'b0;
    logic [9:0] a_in = '0;
    logic [9:0] b_in = '0;
    logic       ready, done, ov, dvz;
    logic [9:0] q_out;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fixed_point_divider_param #(
        .WIDTH (W),
        .FRAC  (F)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a_in        (a_in),
        .b_in        (b_in),
        .ready       (ready),
        .done        (done),
        .q_out       (q_out),
        .ov          (ov),
        .dvz         (dvz)
    );

    function automatic exp_t mk(input logic [9:0] q, input logic o, input logic z);
        exp_t e;
        e.q = q; e.ov = o; e.dvz = z;
        return e;
    endfunction

    // Reference: plain integer arithmetic with truncation toward zero.
    function automatic exp_t model(input logic [9:0] a, input logic [9:0] b, input logic sm);
        longint av, bv, qv;
        logic [63:0] qb;
        av = sm ? longint'($signed(a)) : longint'(a);
        bv = sm ? longint'($signed(b)) : longint'(b);
        if (bv == 0) begin
            if (!sm)        return mk(10'h3FF, 1'b0, 1'b1);
            else if (av < 0) return mk(10'h200, 1'b0, 1'b1);
            else             return mk(10'h1FF, 1'b0, 1'b1);
        end
        qv = (av * 16) / bv;
        qb = qv;
        if (!sm) begin
            if (qv > 1023) return mk(10'h3FF, 1'b1, 1'b0);
        end else begin
            if (qv > 511)  return mk(10'h1FF, 1'b1, 1'b0);
            if (qv < -512) return mk(10'h200, 1'b1, 1'b0);
        end
        return mk(qb[9:0], 1'b0, 1'b0);
    endfunction

    task automatic issue(input logic [9:0] a, input logic [9:0] b, input logic sm,
                         input exp_t e, input bit push);
        if (push) sb.push_back(e);
        a_in = a; b_in = b; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit to);
        cyc = 0; to = 1'b0;
        while (done !== 1'b1) begin
            if (cyc >= 100) begin to = 1'b1; break; end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        n_checks++;
        if ({ready, done, q_out, ov, dvz} !== {1'b1, 1'b0, 10'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got rdy=%b done=%b q=%h ov=%b dvz=%b, expected 1 0 000 0 0",
                     ready, done, q_out, ov, dvz);
        end
    endtask

    // Test-plan vectors with hand-derived expected codes.
    task automatic test_plan_vectors;
        logic [9:0] ta[8] = '{10'd48, 10'd16, 10'd1023, 10'h200, 10'h3D0, 10'd48, 10'd5, 10'h3D0};
        logic [9:0] tb[8] = '{10'd16, 10'd48, 10'd1, 10'd1, 10'd16, 10'h3F0, 10'd0, 10'd0};
        logic       ts[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_t       te[8];
        int         tl[8] = '{LAT, LAT, LAT, LAT, LAT, LAT, 1, 1};
        int   cyc;
        bit   to;
        exp_t e, got;
        te[0] = mk(10'd48, 1'b0, 1'b0);   te[1] = mk(10'd5, 1'b0, 1'b0);
        te[2] = mk(10'h3FF, 1'b1, 1'b0);  te[3] = mk(10'h200, 1'b1, 1'b0);
        te[4] = mk(10'h3D0, 1'b0, 1'b0);  te[5] = mk(10'h3D0, 1'b0, 1'b0);
        te[6] = mk(10'h3FF, 1'b0, 1'b1);  te[7] = mk(10'h200, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            issue(ta[i], tb[i], ts[i], te[i], 1'b1);
            n_checks++;
            if (ready !== 1'b0) begin
                n_fail++;
                $display("FAIL plan%0d_ready_drop: got ready=%b, expected 0", i, ready);
            end
            wait_done(cyc, to);
            got = '{q_out, ov, dvz};
            e = (sb.size() != 0) ? sb.pop_front() : mk(10'hx, 1'bx, 1'bx);
            n_checks++;
            if (to || got !== e) begin
                n_fail++;
                $display("FAIL plan%0d_result: got q=%h ov=%b dvz=%b, expected q=%h ov=%b dvz=%b (timeout=%0d)",
                         i, got.q, got.ov, got.dvz, e.q, e.ov, e.dvz, to);
            end
            n_checks++;
            if (cyc != tl[i]) begin
                n_fail++;
                $display("FAIL plan%0d_latency: got %0d cycles, expected %0d", i, cyc, tl[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random;
        logic [9:0] a, b;
        logic       sm;
        int   cyc;
        bit   to;
        exp_t e, got;
        for (int i = 0; i < 24; i++) begin
            a  = 10'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom);
            sm = 1'($urandom);
            issue(a, b, sm, model(a, b, sm), 1'b1);
            wait_done(cyc, to);
            got = '{q_out, ov, dvz};
            e = (sb.size() != 0) ? sb.pop_front() : mk(10'hx, 1'bx, 1'bx);
            n_checks++;
            if (to || got !== e || cyc != ((b == 0) ? 1 : LAT)) begin
                n_fail++;
                $display("FAIL rand%0d a=%h b=%h sm=%b: got q=%h ov=%b dvz=%b after %0d, expected q=%h ov=%b dvz=%b",
                         i, a, b, sm, got.q, got.ov, got.dvz, cyc, e.q, e.ov, e.dvz);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int   cyc, extra;
        bit   to;
        exp_t e, got;
        issue(10'd100, 10'd7, 1'b0, model(10'd100, 10'd7, 1'b0), 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        a_in = 10'd1; b_in = 10'd0; signed_mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, to);
        got = '{q_out, ov, dvz};
        e = (sb.size() != 0) ? sb.pop_front() : mk(10'hx, 1'bx, 1'bx);
        n_checks++;
        if (to || got !== e || cyc + 4 != LAT) begin
            n_fail++;
            $display("FAIL busy_ignore: got q=%h ov=%b dvz=%b after %0d, expected q=%h ov=%b dvz=%b after %0d",
                     got.q, got.ov, got.dvz, cyc + 4, e.q, e.ov, e.dvz, LAT);
        end
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL busy_no_extra_done: got %0d extra done pulses, expected 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int   cyc;
        bit   to;
        exp_t e, got;
        issue(10'h3D0, 10'd48, 1'b1, model(10'h3D0, 10'd48, 1'b1), 1'b1);
        wait_done(cyc, to);
        got = '{q_out, ov, dvz};
        e = (sb.size() != 0) ? sb.pop_front() : mk(10'hx, 1'bx, 1'bx);
        n_checks++;
        if (to || got !== e) begin
            n_fail++;
            $display("FAIL b2b_first: got q=%h ov=%b dvz=%b, expected q=%h ov=%b dvz=%b",
                     got.q, got.ov, got.dvz, e.q, e.ov, e.dvz);
        end
        // Start issued in the done cycle.
        issue(10'd200, 10'd3, 1'b0, model(10'd200, 10'd3, 1'b0), 1'b1);
        n_checks++;
        if ({done, ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_accept: got done=%b ready=%b, expected 0 0", done, ready);
        end
        wait_done(cyc, to);
        got = '{q_out, ov, dvz};
        e = (sb.size() != 0) ? sb.pop_front() : mk(10'hx, 1'bx, 1'bx);
        n_checks++;
        if (to || got !== e || cyc != LAT) begin
            n_fail++;
            $display("FAIL b2b_second: got q=%h ov=%b dvz=%b after %0d, expected q=%h ov=%b dvz=%b after %0d",
                     got.q, got.ov, got.dvz, cyc, e.q, e.ov, e.dvz, LAT);
        end
        issue(10'd48, 10'd0, 1'b1, mk(10'h1FF, 1'b0, 1'b1), 1'b1);
        wait_done(cyc, to);
        got = '{q_out, ov, dvz};
        e = (sb.size() != 0) ? sb.pop_front() : mk(10'hx, 1'bx, 1'bx);
        n_checks++;
        if (to || got !== e || cyc != 1) begin
            n_fail++;
            $display("FAIL b2b_dvz: got q=%h ov=%b dvz=%b after %0d, expected q=%h ov=%b dvz=%b after 1",
                     got.q, got.ov, got.dvz, cyc, e.q, e.ov, e.dvz);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_single_pulse: got done=%b, expected 0", done);
        end
    endtask

    task automatic test_reset_mid;
        int   cyc, seen;
        bit   to;
        exp_t e, got;
        issue(10'd300, 10'd9, 1'b0, mk(10'h0, 1'b0, 1'b0), 1'b0);
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({ready, done, q_out, ov, dvz} !== {1'b1, 1'b0, 10'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: got rdy=%b done=%b q=%h ov=%b dvz=%b, expected 1 0 000 0 0",
                     ready, done, q_out, ov, dvz);
        end
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, expected 0", seen);
        end
        issue(10'd300, 10'd9, 1'b0, model(10'd300, 10'd9, 1'b0), 1'b1);
        wait_done(cyc, to);
        got = '{q_out, ov, dvz};
        e = (sb.size() != 0) ? sb.pop_front() : mk(10'hx, 1'bx, 1'bx);
        n_checks++;
        if (to || got !== e || cyc != LAT) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got q=%h ov=%b dvz=%b after %0d, expected q=%h ov=%b dvz=%b after %0d",
                     got.q, got.ov, got.dvz, cyc, e.q, e.ov, e.dvz, LAT);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_point_divider_param.md
# fixed_point_divider_param

Parametrised sequential fixed-point divider, the next generation of the team's 10-bit restoring divider. Computes Q = (A << FRAC) / B on WIDTH-bit operands, one quotient bit per cycle. Adds a start/ready/done handshake, a run-time signed/unsigned mode, and saturation on overflow. Sits behind the arithmetic datapath controller, which loads operands and consumes the quotient when done pulses.

## Interface
Parameters:
- WIDTH, 10: operand and quotient width in bits.
- FRAC, 4: fractional bits in the operand and quotient format; must satisfy 0 <= FRAC < WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- signed_mode  input  1  0 = unsigned operands; 1 = two's-complement operands. Captured with start.
- a_in  input  WIDTH  dividend; captured with start.
- b_in  input  WIDTH  divisor; captured with start.
- ready  output  1  high in IDLE.
- done  output  1  single-cycle pulse; q_out and the flags are valid from this cycle.
- q_out  output  WIDTH  quotient in the same fixed-point format as the operands.
- ov  output  1  quotient did not fit in WIDTH bits; q_out saturated.
- dvz  output  1  divisor was zero.

## Operation
- States: IDLE, RUN, FIN.
- IDLE, start=1: capture signed_mode, the operand magnitudes, and the result sign (a_sign XOR b_sign, or 0 when unsigned).
  - b_in=0: next state FIN with dvz pending.
  - Otherwise: next state RUN; iteration counter = 0; remainder = 0; dividend shift register = |A| << FRAC (WIDTH+FRAC bits).
- RUN, each cycle: shift the next dividend bit into the remainder (WIDTH+1 bits). If remainder >= |B|, subtract |B| and shift 1 into the quotient, else shift 0.
  - The counter runs 0..N-1, with N = WIDTH+FRAC. At N-1, next state is FIN.
- FIN: form the final result from the raw magnitude quotient R (N bits).
  - Unsigned: ov = (R >= 2^WIDTH); q = ov ? all-ones : R[WIDTH-1:0].
  - Signed, positive result: ov = (R > 2^(WIDTH-1)-1); saturates to 0111...1.
  - Signed, negative result: ov = (R > 2^(WIDTH-1)); saturates to 1000...0; otherwise q = -R.
  - dvz case: dvz=1, ov=0. q = all-ones when unsigned. When signed, q = 0111...1 if A >= 0, else 1000...0.
  - Next state is IDLE. done=1 and the outputs are registered on this edge.
- q_out, ov, and dvz hold until the next FIN edge.
- start while RUN or FIN is ignored.
- Back-to-back: start may be accepted in the same cycle that done is high.
- Magnitude of the most-negative input is 2^(WIDTH-1) and fits in WIDTH unsigned bits; no special case.

## Timing
- Reset values: state IDLE, ready=1, done=0, q_out=0, ov=0, dvz=0, counter=0.
- Reset mid-operation aborts the operation and gives the reset values on the next cycle. No done is produced.
- Latency, with edge 0 being the edge that samples start:
  - Normal: done is high after edge N+1 (15 cycles at the defaults).
  - Divide by zero: done is high after edge 1.
- ready drops after edge 0 and returns with done.
- done is never high for two consecutive cycles.

## Structure
- Package fxdiv_pkg holds:
  - the state enum (IDLE, RUN, FIN);
  - a function computing N = WIDTH+FRAC;
  - a function returning the saturation constants for a given width and signedness.
- Sub-module fxdiv_iter_counter: parametrised mod-N counter with synchronous clear and enable, and a terminal-count output. It replaces the former fixed mod-14 counter.
- The remainder/quotient datapath and the FSM live in the top module.

## Test plan
(WIDTH=10, FRAC=4; values are raw register codes.)
- Unsigned 48/16 (3.0/1.0) -> q=48, ov=0, dvz=0; done exactly 15 cycles after start.
- Unsigned 16/48 (1.0/3.0) -> q=5 (0.3125, truncated), ov=0.
- Unsigned 1023/1 -> ov=1, q=1023. Signed 10'h200/1 -> ov=1, q=10'h200.
- Signed 10'h3D0 (-3.0) / 16 (1.0) -> q=10'h3D0, ov=0. Signed 48 / 10'h3F0 (-1.0) -> q=10'h3D0.
- b_in=0: unsigned -> dvz=1, q=10'h3FF, done 1 cycle after start. Signed, A negative -> q=10'h200.
- rst at RUN cycle 7 -> IDLE next cycle, no done. A new start then completes normally. A start pulsed while busy is ignored, and a back-to-back start in the done cycle is accepted.
